// File: rtl/pdm_pkg.sv
// Shared constants, types and the PCM saturation helper for the PDM microphone receiver.
package pdm_pkg;

  localparam int CIC_ORDER = 3;
  localparam int ACC_W     = 20;
  localparam int PCM_W     = 16;
  localparam int WARMUP    = 3;
  localparam int PCM_SHIFT = 3;
  localparam int PCM_MAX   = (1 << (PCM_W - 1)) - 1;
  localparam int PCM_MIN   = -(1 << (PCM_W - 1));

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [PCM_W-1:0] pcm_t;

  // Full-scale CIC output is +/-2^18, so after the shift only +2^15 can overflow.
  function automatic pcm_t sat_pcm(input acc_t y);
    acc_t s;
    s = y >>> PCM_SHIFT;
    if (int'(s) > PCM_MAX) return pcm_t'(PCM_MAX);
    if (int'(s) < PCM_MIN) return pcm_t'(PCM_MIN);
    return pcm_t'(s[PCM_W-1:0]);
  endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// Microphone clock divider; flags the system cycle on which m_clk falls so a bit is captured.
module pdm_clk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic m_clk,
  output logic fall_stb
);

  localparam int CNT_W = 8;

  logic [CNT_W-1:0] div_cnt_reg;
  logic             m_clk_reg;
  logic             wrap;

  assign wrap = (div_cnt_reg == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
      m_clk_reg   <= 1'b0;
    end else if (!enable) begin
      div_cnt_reg <= '0;
      m_clk_reg   <= 1'b0;
    end else if (wrap) begin
      div_cnt_reg <= '0;
      m_clk_reg   <= ~m_clk_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign m_clk    = m_clk_reg;
  assign fall_stb = enable & wrap & m_clk_reg;

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver: synchronizer, 3rd-order CIC decimator and a one-deep
// valid/ready output register with sticky overrun.
module pdm_mic_rx
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 50,
  parameter int DECIM   = 64
) (
  input  logic                    CLK100MHZ,
  input  logic                    CPU_RESETN,
  input  logic                    enable,
  output logic                    m_clk,
  output logic                    m_lrsel,
  input  logic                    m_data,
  output logic signed [PCM_W-1:0] pcm_data,
  output logic                    pcm_valid,
  input  logic                    pcm_ready,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  localparam int BC_W = $clog2(DECIM);
  localparam int WC_W = $clog2(WARMUP + 1);

  logic            fall_stb;
  logic [1:0]      sync_reg;
  logic [BC_W-1:0] bit_cnt_reg;
  logic [WC_W-1:0] warm_cnt_reg;
  logic            comb_stb_reg;
  logic            present_stb_reg;
  acc_t            int_reg  [CIC_ORDER];
  acc_t            dly_reg  [CIC_ORDER];
  acc_t            int_next [CIC_ORDER];
  acc_t            comb_out [CIC_ORDER];
  acc_t            x_in;
  acc_t            y_reg;
  pcm_t            pcm_data_reg;
  logic            pcm_valid_reg;
  logic            overrun_reg;
  logic            take;
  logic            ovr_evt;

  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (CLK100MHZ),
    .rst_n    (CPU_RESETN),
    .enable   (enable),
    .m_clk    (m_clk),
    .fall_stb (fall_stb)
  );

  // Unpipelined cascades: the comb result includes the bit captured in the same window.
  always_comb begin
    x_in        = sync_reg[1] ? acc_t'(1) : acc_t'(-1);
    int_next[0] = int_reg[0] + x_in;
    for (int i = 1; i < CIC_ORDER; i++) begin
      int_next[i] = int_reg[i] + int_next[i-1];
    end
    comb_out[0] = int_reg[CIC_ORDER-1] - dly_reg[0];
    for (int i = 1; i < CIC_ORDER; i++) begin
      comb_out[i] = comb_out[i-1] - dly_reg[i];
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync_reg        <= '0;
      bit_cnt_reg     <= '0;
      warm_cnt_reg    <= '0;
      comb_stb_reg    <= 1'b0;
      present_stb_reg <= 1'b0;
      y_reg           <= '0;
      for (int i = 0; i < CIC_ORDER; i++) begin
        int_reg[i] <= '0;
        dly_reg[i] <= '0;
      end
    end else begin
      sync_reg <= {sync_reg[0], m_data};
      if (!enable) begin
        bit_cnt_reg     <= '0;
        warm_cnt_reg    <= '0;
        comb_stb_reg    <= 1'b0;
        present_stb_reg <= 1'b0;
        y_reg           <= '0;
        for (int i = 0; i < CIC_ORDER; i++) begin
          int_reg[i] <= '0;
          dly_reg[i] <= '0;
        end
      end else begin
        comb_stb_reg    <= 1'b0;
        present_stb_reg <= 1'b0;
        if (fall_stb) begin
          for (int i = 0; i < CIC_ORDER; i++) begin
            int_reg[i] <= int_next[i];
          end
          if (bit_cnt_reg == BC_W'(DECIM - 1)) begin
            bit_cnt_reg  <= '0;
            comb_stb_reg <= 1'b1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        if (comb_stb_reg) begin
          dly_reg[0] <= int_reg[CIC_ORDER-1];
          for (int i = 1; i < CIC_ORDER; i++) begin
            dly_reg[i] <= comb_out[i-1];
          end
          y_reg <= comb_out[CIC_ORDER-1];
          // The first results still carry the zero start-up history of the combs.
          if (warm_cnt_reg == WC_W'(WARMUP)) begin
            present_stb_reg <= 1'b1;
          end else begin
            warm_cnt_reg <= warm_cnt_reg + 1'b1;
          end
        end
      end
    end
  end

  assign take    = pcm_valid_reg & pcm_ready;
  assign ovr_evt = present_stb_reg & pcm_valid_reg & ~pcm_ready;

  // Output stage is not gated by enable so a held sample survives until it is taken.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pcm_data_reg  <= '0;
      pcm_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (present_stb_reg) begin
        pcm_data_reg  <= sat_pcm(y_reg);
        pcm_valid_reg <= 1'b1;
      end else if (take) begin
        pcm_valid_reg <= 1'b0;
      end
      if (ovr_evt) begin
        overrun_reg <= 1'b1;
      end else if (clr_overrun) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign pcm_data  = pcm_data_reg;
  assign pcm_valid = pcm_valid_reg;
  assign overrun   = overrun_reg;
  assign m_lrsel   = 1'b0;

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Bench for pdm_mic_rx: scenario table plus hand sequences, checked every cycle against
// a model that filters the captured bit stream with the CIC impulse response.
module tb_pdm_mic_rx;

  localparam int CLK_DIV = 3;
  localparam int DECIM   = 64;
  localparam int WARMUP  = 3;
  localparam int WIN_CYC = 2 * CLK_DIV * DECIM;
  localparam int HLEN    = 3 * DECIM - 2;
  localparam int M_ONES  = 0;
  localparam int M_ZEROS = 1;
  localparam int M_ALT   = 2;
  localparam int M_RAND  = 3;

  logic clk = 1'b0;
  logic rst_n, enable, m_data, pcm_ready, clr_overrun;
  logic m_clk, m_lrsel, pcm_valid, overrun;
  logic signed [15:0] pcm_data;

  pdm_mic_rx #(.CLK_DIV(CLK_DIV), .DECIM(DECIM)) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .enable      (enable),
    .m_clk       (m_clk),
    .m_lrsel     (m_lrsel),
    .m_data      (m_data),
    .pcm_data    (pcm_data),
    .pcm_valid   (pcm_valid),
    .pcm_ready   (pcm_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode;
    int nwin;
    int ready_pol;
    bit use_const;
    int exp_pcm;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int h [HLEN];
  int bits [$];
  int edge_cnt = 0;
  int en_edges, due_edge, due_val, exp_data, result_cnt, last_val;
  bit exp_valid, exp_ovr, p1, p2;
  int mode = M_RAND;
  bit const_on = 0;
  int const_exp = 0;
  bit period_on = 0;
  int last_rise = -1;
  int dut_rise = 0;
  bit prev_valid = 0;

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, edge_cnt);
      if (errors >= 40) finish_run();
    end
  endtask

  task automatic model_reset();
    bits.delete();
    en_edges  = 0;
    due_edge  = -1;
    exp_valid = 0;
    exp_data  = 0;
    exp_ovr   = 0;
    p1        = 0;
    p2        = 0;
  endtask

  // y = sum of h[j]*x[n-j]; h is the (1 + z^-1 + ... + z^-63)^3 kernel.
  function automatic int model_pcm();
    int n, y, q;
    n = bits.size() - 1;
    y = 0;
    for (int j = 0; j < HLEN; j++) y += h[j] * bits[n-j];
    q = y >>> 3;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic tick();
    bit en_s, md_s, rdy_s, clr_s, newr, ovr_evt, captured;
    en_s  = enable;
    md_s  = m_data;
    rdy_s = pcm_ready;
    clr_s = clr_overrun;
    captured = 0;
    if (pcm_valid && pcm_ready) $display("xfer cycle %0d pcm_data %0d", edge_cnt + 1, pcm_data);
    @(posedge clk);
    edge_cnt++;
    newr    = (due_edge == edge_cnt);
    ovr_evt = 0;
    if (newr) begin
      ovr_evt   = exp_valid && !rdy_s;
      exp_data  = due_val;
      exp_valid = 1;
      due_edge  = -1;
      result_cnt++;
      last_val  = due_val;
    end else if (exp_valid && rdy_s) begin
      exp_valid = 0;
    end
    if (ovr_evt) exp_ovr = 1;
    else if (clr_s) exp_ovr = 0;
    if (en_s) begin
      en_edges++;
      if (en_edges % (2 * CLK_DIV) == 0) begin
        captured = 1;
        bits.push_back(p2 ? 1 : -1);
        if (bits.size() % DECIM == 0 && bits.size() / DECIM > WARMUP) begin
          due_edge = edge_cnt + 2;
          due_val  = model_pcm();
        end
      end
    end else begin
      en_edges = 0;
      bits.delete();
      if (due_edge > edge_cnt) due_edge = -1;
    end
    p2 = p1;
    p1 = md_s;
    #1;
    check("pcm_valid", int'(pcm_valid), int'(exp_valid));
    if (exp_valid) check("pcm_data", int'(pcm_data), exp_data);
    check("overrun", int'(overrun), int'(exp_ovr));
    check("m_clk", int'(m_clk), (en_edges / CLK_DIV) % 2);
    check("m_lrsel", int'(m_lrsel), 0);
    if (const_on && pcm_valid) check("const_pcm", int'(pcm_data), const_exp);
    if (pcm_valid && !prev_valid) begin
      dut_rise++;
      if (period_on && last_rise >= 0) check("sample_period", edge_cnt - last_rise, WIN_CYC);
      last_rise = edge_cnt;
    end
    prev_valid = pcm_valid;
    if (mode == M_RAND) m_data = 1'($urandom_range(0, 1));
    else if (mode == M_ALT && captured) m_data = ~m_data;
  endtask

  task automatic wait_result(input int limit);
    int start, n;
    start = result_cnt;
    n = 0;
    while (result_cnt == start && n < limit) begin
      tick();
      n++;
    end
    check("result_timeout", int'(result_cnt != start), 1);
  endtask

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    vec_t vt [5];
    int n, first;
    vt[0] = '{M_ONES,  6, 1, 1'b1, 32767};
    vt[1] = '{M_ZEROS, 6, 1, 1'b1, -32768};
    vt[2] = '{M_ALT,   6, 1, 1'b1, 0};
    vt[3] = '{M_RAND,  8, 1, 1'b0, 0};
    vt[4] = '{M_RAND,  8, 2, 1'b0, 0};

    for (int j = 0; j < HLEN; j++) h[j] = 0;
    for (int a = 0; a < DECIM; a++)
      for (int b = 0; b < DECIM; b++)
        for (int c = 0; c < DECIM; c++)
          h[a+b+c]++;

    rst_n = 0; enable = 0; m_data = 0; pcm_ready = 1; clr_overrun = 0;
    result_cnt = 0; last_val = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_m_clk", int'(m_clk), 0);
    check("reset_m_lrsel", int'(m_lrsel), 0);
    check("reset_pcm_data", int'(pcm_data), 0);
    check("reset_pcm_valid", int'(pcm_valid), 0);
    check("reset_overrun", int'(overrun), 0);
    rst_n = 1;
    repeat (4) tick();

    for (int v = 0; v < 5; v++) begin
      enable    = 0;
      mode      = vt[v].mode;
      m_data    = (mode == M_ZEROS) ? 1'b0 : 1'b1;
      pcm_ready = (vt[v].ready_pol == 1);
      repeat (4) tick();
      const_on  = vt[v].use_const;
      const_exp = vt[v].exp_pcm;
      period_on = (vt[v].ready_pol == 1);
      last_rise = -1;
      dut_rise  = 0;
      enable    = 1;
      for (int c = 0; c < vt[v].nwin * WIN_CYC + 4; c++) begin
        if (vt[v].ready_pol == 2) pcm_ready = 1'($urandom_range(0, 1));
        tick();
      end
      if (vt[v].ready_pol == 1) check("sample_count", dut_rise, vt[v].nwin - WARMUP);
      const_on  = 0;
      period_on = 0;
      pcm_ready = 1;
      repeat (4) tick();
    end

    // Overrun: two results with no consumer, then clear, then set-wins-over-clear.
    mode = M_RAND;
    enable = 0; pcm_ready = 0;
    repeat (3) tick();
    enable = 1;
    wait_result(6 * WIN_CYC);
    wait_result(2 * WIN_CYC);
    check("ovr_set", int'(overrun), 1);
    check("ovr_valid", int'(pcm_valid), 1);
    check("ovr_data", int'(pcm_data), last_val);
    clr_overrun = 1;
    tick();
    clr_overrun = 0;
    check("ovr_clr", int'(overrun), 0);
    clr_overrun = 1;
    wait_result(2 * WIN_CYC);
    check("ovr_set_wins", int'(overrun), 1);
    tick();
    clr_overrun = 0;
    check("ovr_clr2", int'(overrun), 0);

    // Ready raised on exactly the cycle a new result lands.
    n = 0;
    while (due_edge != edge_cnt + 1 && n < 2 * WIN_CYC) begin
      tick();
      n++;
    end
    check("due_timeout", int'(n < 2 * WIN_CYC), 1);
    pcm_ready = 1;
    tick();
    check("same_cycle_valid", int'(pcm_valid), 1);
    check("same_cycle_ovr", int'(overrun), 0);
    check("same_cycle_data", int'(pcm_data), last_val);
    tick();
    check("same_cycle_taken", int'(pcm_valid), 0);

    // Held sample survives enable falling.
    pcm_ready = 0;
    wait_result(2 * WIN_CYC);
    enable = 0;
    repeat (10) tick();
    check("retain_valid", int'(pcm_valid), 1);
    check("retain_data", int'(pcm_data), last_val);
    pcm_ready = 1;
    tick();
    check("retain_taken", int'(pcm_valid), 0);

    // Reset mid-window with outputs busy, then enable toggled.
    pcm_ready = 0;
    enable = 1;
    repeat (5 * WIN_CYC + WIN_CYC / 2) tick();
    #3;
    rst_n = 0;
    #1;
    check("rst_pcm_data", int'(pcm_data), 0);
    check("rst_pcm_valid", int'(pcm_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_m_clk", int'(m_clk), 0);
    model_reset();
    enable = 0;
    pcm_ready = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (20) tick();
    enable = 1;
    repeat (2 * WIN_CYC + WIN_CYC / 3) tick();
    enable = 0;
    repeat (5) tick();
    check("idle_m_clk", int'(m_clk), 0);
    enable = 1;
    first = -1;
    for (int c = 0; c < (WARMUP + 2) * WIN_CYC; c++) begin
      tick();
      if (first < 0 && pcm_valid) first = c + 1;
    end
    check("first_valid_after_enable", first, (WARMUP + 1) * WIN_CYC + 2);

    finish_run();
  end

endmodule

// File: doc/pdm_mic_rx.md
PDM_MIC_RX -- requirements
Module: pdm_mic_rx

Interface
REQ-001 Parameter CLK_DIV, default 50: system cycles per m_clk half-period (100 MHz -> 1 MHz m_clk); legal 2..255.
REQ-002 Parameter DECIM, default 64: PDM bits per PCM sample (15.625 kHz at 1 MHz); fixed at 64 for the gain rules below.
REQ-003 CLK100MHZ  in  1  system clock, 100 MHz, single clock domain.
REQ-004 CPU_RESETN  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  high = run microphone and decimator.
REQ-006 m_clk  out  1  microphone clock.
REQ-007 m_lrsel  out  1  microphone channel select, constant 0.
REQ-008 m_data  in  1  PDM bit from the microphone, asynchronous to CLK100MHZ.
REQ-009 pcm_data  out  16  signed two's-complement PCM sample.
REQ-010 pcm_valid  out  1  pcm_data holds an untaken sample.
REQ-011 pcm_ready  in  1  consumer accepts the sample on a cycle with pcm_valid high.
REQ-012 overrun  out  1  sticky: an untaken sample was overwritten.
REQ-013 clr_overrun  in  1  synchronous clear of overrun.

Function
REQ-014 Divider counts 0..CLK_DIV-1; m_clk toggles on wrap; with enable low, m_clk is held 0 and the divider is held at 0.
REQ-015 m_data passes through a 2-flop synchronizer; one bit is captured on each system cycle where m_clk toggles 1->0.
REQ-016 Captured bit 1 maps to +1 and bit 0 maps to -1, feeding a 3rd-order CIC decimator.
REQ-017 Integrators and combs are 20-bit signed with modular wrap-around; wrap is required and is not an error.
REQ-018 A bit counter 0..DECIM-1 triggers one comb update per DECIM captured bits.
REQ-019 Comb output y lies in [-262144, +262144]; pcm = y >>> 3, saturated to [-32768, +32767].
REQ-020 After reset or an enable rising edge, the first 3 decimated results are discarded (warm-up); later results are presented.
REQ-021 pcm_valid rises exactly 2 CLK100MHZ cycles after capture of the DECIM-th bit of a decimation window.
REQ-022 Handshake: the transfer completes on a cycle with pcm_valid & pcm_ready; pcm_data stays stable while pcm_valid & !pcm_ready.
REQ-023 New result with pcm_valid high and no transfer that cycle: pcm_data is overwritten with the new result, pcm_valid stays high, and overrun is set.
REQ-024 New result on the same cycle as a transfer: the new result is loaded, pcm_valid stays high, and overrun is not set.
REQ-025 If clr_overrun and an overrun event occur on the same cycle, overrun ends up 1 (set wins).
REQ-026 enable falling: integrators, combs, bit counter and warm-up count clear on the next cycle; the output register and pcm_valid are retained until taken.

Reset
REQ-027 CPU_RESETN low asynchronously clears all state: m_clk=0, m_lrsel=0, pcm_data=0, pcm_valid=0, overrun=0, all counters, integrators, combs and synchronizer flops=0.
REQ-028 Reset mid-window discards the partial window; no sample is emitted for it.
REQ-029 Reset release is synchronous to CLK100MHZ; the first capture occurs at the first m_clk 1->0 toggle after release with enable high.

Structure
REQ-030 Package pdm_pkg holds CIC_ORDER=3, ACC_W=20, PCM_W=16, WARMUP=3 and the saturation function.
REQ-031 Sub-module pdm_clk_gen contains the divider, m_clk and the capture strobe; the CIC stages and output register stay in pdm_mic_rx.

Verification
REQ-032 Constant m_data=1, pcm_ready=1 -> after warm-up every sample is +32767 (saturated), one sample per 6400 cycles.
REQ-033 Constant m_data=0 -> every post-warm-up sample is -32768; alternating 1,0 bits -> every sample is 0.
REQ-034 pcm_ready=0 across two results -> pcm_data equals the second result, overrun=1; clr_overrun pulse -> overrun=0.
REQ-035 pcm_ready asserted on the cycle a new result arrives -> old sample transferred, new sample valid, overrun stays 0.
REQ-036 CPU_RESETN pulsed low mid-window, then enable toggled -> all outputs 0 immediately, m_clk held 0 while enable low, 3 discarded results before the next pcm_valid.
